// File: rtl/mcpu_pkg.sv
// Shared fetch-stage types and constants for the mcpu core.
// The queue entry carries a fixed 16-bit pc field. Narrower address widths are zero-extended.
package mcpu_pkg;

   localparam int unsigned PC_BITS = 16;
   localparam int unsigned LEN_BIT = 7;
   localparam logic [7:0]  HALT_OP = 8'hFF;

   typedef struct packed {
      logic [PC_BITS-1:0] pc;
      logic [7:0]         op;
      logic [7:0]         arg;
      logic [1:0]         len;
   } fetch_entry_t;

   localparam int unsigned ENTRY_BITS = $bits(fetch_entry_t);

   function automatic logic [1:0] instr_length(input logic [7:0] op);
      return op[LEN_BIT] ? 2'd2 : 2'd1;
   endfunction

   function automatic logic is_halt_op(input logic [7:0] op);
      return op == HALT_OP;
   endfunction

endpackage

// File: rtl/mcpu_fetch_fifo.sv
// Two-entry shifting queue. The head register drives the consumer directly.
// flush empties the queue and takes priority over push and pop.
module mcpu_fetch_fifo #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       count,
   output logic             valid
);

   logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
   logic [1:0]       count_q, count_d;
   logic             do_pop;

   assign do_pop = pop && (count_q != 2'd0);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         count_d = 2'd0;
      end else begin
         case ({push, do_pop})
            2'b10: begin
               if (count_q == 2'd0) head_d = push_data;
               else                 tail_d = push_data;
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               if (count_q == 2'd2) head_d = tail_q;
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               // Count unchanged. The older tail moves to the head before the new entry lands.
               if (count_q == 2'd2) begin
                  head_d = tail_q;
                  tail_d = push_data;
               end else begin
                  head_d = push_data;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign head  = head_q;
   assign count = count_q;
   assign valid = (count_q != 2'd0);

endmodule

// File: rtl/mcpu_fetch.sv
// Instruction fetch with a pc register, a RUN/HALT FSM and a 2-deep instruction queue.
// Defining MCPU_FETCH_HALT_EN stops fetch after opcode 0xFF until the next redirect.
module mcpu_fetch
   import mcpu_pkg::*;
#(
   parameter int unsigned               IROM_ADDR_BITS = 14,
   parameter logic [IROM_ADDR_BITS-1:0] RESET_VECTOR   = '0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   output logic [IROM_ADDR_BITS-1:0] irom_addr0,
   input  logic [7:0]                irom_out0,
   output logic [IROM_ADDR_BITS-1:0] irom_addr1,
   input  logic [7:0]                irom_out1,
   input  logic                      redirect_valid,
   input  logic [IROM_ADDR_BITS-1:0] redirect_addr,
   output logic                      instr_valid,
   input  logic                      instr_ready,
   output logic [7:0]                instr_op,
   output logic [7:0]                instr_arg,
   output logic [IROM_ADDR_BITS-1:0] instr_pc,
   output logic [1:0]                instr_len
);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   logic [0:0]                state_q, state_d;
   logic [IROM_ADDR_BITS-1:0] pc_q, pc_d;
   logic [1:0]                len;
   logic [1:0]                count;
   logic                      handshake, enq, halted;
   fetch_entry_t              new_entry, head;
   logic [ENTRY_BITS-1:0]     head_bits;
   logic                      unused_head_pc;

   assign irom_addr0 = pc_q;
   assign irom_addr1 = pc_q + IROM_ADDR_BITS'(1);
   assign len        = instr_length(irom_out0);

   always_comb begin
      new_entry     = '0;
      new_entry.pc  = PC_BITS'(pc_q);
      new_entry.op  = irom_out0;
      new_entry.arg = (len == 2'd2) ? irom_out1 : 8'h00;
      new_entry.len = len;
   end

   assign halted    = (state_q == ST_HALT);
   assign handshake = instr_valid && instr_ready;
   // A head consumed on this edge frees a slot for the fetch on the same edge.
   assign enq = !halted && !redirect_valid && ((count < 2'd2) || handshake);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (redirect_valid) begin
         state_d = ST_RUN;
         pc_d    = redirect_addr;
      end else if (enq) begin
         pc_d = pc_q + IROM_ADDR_BITS'(len);
`ifdef MCPU_FETCH_HALT_EN
         if (is_halt_op(irom_out0)) state_d = ST_HALT;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_VECTOR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   mcpu_fetch_fifo #(
      .WIDTH(ENTRY_BITS)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect_valid),
      .push     (enq),
      .push_data(new_entry),
      .pop      (handshake),
      .head     (head_bits),
      .count    (count),
      .valid    (instr_valid)
   );

   assign head           = head_bits;
   assign instr_op       = head.op;
   assign instr_arg      = head.arg;
   assign instr_pc       = head.pc[IROM_ADDR_BITS-1:0];
   assign instr_len      = head.len;
   assign unused_head_pc = ^head.pc;

endmodule

// File: tb/tb_mcpu_fetch.sv
// Directed bench for mcpu_fetch. A queue-based model is checked every cycle, and literal checks pin it.
module tb_mcpu_fetch;

   localparam int AW   = 14;
   localparam int ROMN = 1 << AW;
`ifdef MCPU_FETCH_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] irom_addr0, irom_addr1, redirect_addr, instr_pc;
   logic [7:0]    irom_out0, irom_out1, instr_op, instr_arg;
   logic          redirect_valid, instr_valid, instr_ready;
   logic [1:0]    instr_len;
   logic [7:0]    rom [0:ROMN-1];

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int pc;
      int op;
      int arg;
      int len;
   } ent_t;

   ent_t q[$];
   int   mpc;
   bit   mhalted;

   mcpu_fetch dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .irom_addr0    (irom_addr0),
      .irom_out0     (irom_out0),
      .irom_addr1    (irom_addr1),
      .irom_out1     (irom_out1),
      .redirect_valid(redirect_valid),
      .redirect_addr (redirect_addr),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr_op      (instr_op),
      .instr_arg     (instr_arg),
      .instr_pc      (instr_pc),
      .instr_len     (instr_len)
   );

   assign irom_out0 = rom[irom_addr0];
   assign irom_out1 = rom[irom_addr1];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int op, len, arg;
      bit hs;
      hs = (q.size() != 0) && instr_ready;
      if (redirect_valid) begin
         q.delete();
         mpc     = int'(redirect_addr);
         mhalted = 1'b0;
      end else begin
         if (hs) void'(q.pop_front());
         if (!mhalted && q.size() < 2) begin
            op  = int'(rom[mpc]);
            len = (op >= 128) ? 2 : 1;
            arg = (len == 2) ? int'(rom[(mpc + 1) % ROMN]) : 0;
            q.push_back('{pc: mpc, op: op, arg: arg, len: len});
            mpc = (mpc + len) % ROMN;
            if (HALT_EN && op == 255) mhalted = 1'b1;
         end
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         q.delete();
         mpc     = 0;
         mhalted = 1'b0;
      end else begin
         model_step();
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_valid", 32'(instr_valid), 0);
         check("rst_op", 32'(instr_op), 0);
         check("rst_pc", 32'(instr_pc), 0);
      end else begin
         check("m_valid", 32'(instr_valid), (q.size() != 0) ? 1 : 0);
         if (q.size() != 0) begin
            check("m_pc", 32'(instr_pc), q[0].pc);
            check("m_op", 32'(instr_op), q[0].op);
            check("m_arg", 32'(instr_arg), q[0].arg);
            check("m_len", 32'(instr_len), q[0].len);
         end
         check("m_addr0", 32'(irom_addr0), mpc);
         check("m_addr1", 32'(irom_addr1), (mpc + 1) % ROMN);
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, 32'(instr_valid), 0);
      check({tag, "_op"}, 32'(instr_op), 0);
      check({tag, "_arg"}, 32'(instr_arg), 0);
      check({tag, "_pc"}, 32'(instr_pc), 0);
      check({tag, "_len"}, 32'(instr_len), 0);
      check({tag, "_addr0"}, 32'(irom_addr0), 0);
   endtask

   task automatic redirect(input int addr);
      redirect_valid = 1'b1;
      redirect_addr  = AW'(addr);
      @(negedge clk);
      redirect_valid = 1'b0;
   endtask

   initial begin
      int seen;
      mpc     = 0;
      mhalted = 1'b0;
      for (int i = 0; i < ROMN; i++) rom[i] = 8'h00;
      rom[0]      = 8'h01;
      rom[1]      = 8'h85;
      rom[2]      = 8'h33;
      rom[16'h100] = 8'h07;
      rom[16'h101] = 8'h88;
      rom[16'h102] = 8'h11;
      rom[16'h3FFF] = 8'h80;
      rom[16'h10] = 8'hFF;
      rom[16'h11] = 8'h22;
      rom[16'h12] = 8'h01;
      rom[16'h20] = 8'h0A;
      rst_n          = 1'b0;
      instr_ready    = 1'b1;
      redirect_valid = 1'b0;
      redirect_addr  = '0;

      #1 check_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // First instruction is enqueued on the first edge after release.
      @(negedge clk);
      check("r_valid", 32'(instr_valid), 1);
      check("r_pc0", 32'(instr_pc), 0);
      check("r_op0", 32'(instr_op), 32'h01);
      check("r_len0", 32'(instr_len), 1);
      check("r_arg0", 32'(instr_arg), 0);
      @(negedge clk);
      check("r_pc1", 32'(instr_pc), 1);
      check("r_op1", 32'(instr_op), 32'h85);
      check("r_arg1", 32'(instr_arg), 32'h33);
      check("r_len1", 32'(instr_len), 2);
      check("r_nextpc", 32'(irom_addr0), 3);

      // Backpressure: the queue fills with pc1 and pc3, then fetch stops at 4.
      instr_ready = 1'b0;
      repeat (5) @(negedge clk);
      check("bp_pc", 32'(instr_pc), 1);
      check("bp_op", 32'(instr_op), 32'h85);
      check("bp_addr", 32'(irom_addr0), 4);

      redirect(16'h100);
      check("rd_bubble", 32'(instr_valid), 0);
      check("rd_addr", 32'(irom_addr0), 32'h100);
      instr_ready = 1'b1;
      @(negedge clk);
      check("rd_valid", 32'(instr_valid), 1);
      check("rd_pc", 32'(instr_pc), 32'h100);
      check("rd_op", 32'(instr_op), 32'h07);
      @(negedge clk);
      check("rd_pc2", 32'(instr_pc), 32'h101);
      check("rd_arg2", 32'(instr_arg), 32'h11);

      // Address wrap: the operand of the last ROM byte comes from address 0.
      rom[0] = 8'h5A;
      redirect(16'h3FFF);
      check("wr_addr1", 32'(irom_addr1), 0);
      @(negedge clk);
      check("wr_pc", 32'(instr_pc), 32'h3FFF);
      check("wr_op", 32'(instr_op), 32'h80);
      check("wr_arg", 32'(instr_arg), 32'h5A);
      check("wr_len", 32'(instr_len), 2);
      check("wr_next", 32'(irom_addr0), 1);
      @(negedge clk);
      check("wr_pc2", 32'(instr_pc), 1);

      redirect(16'h10);
      @(negedge clk);
      check("ff_pc", 32'(instr_pc), 32'h10);
      check("ff_op", 32'(instr_op), 32'hFF);
      check("ff_arg", 32'(instr_arg), 32'h22);
      check("ff_len", 32'(instr_len), 2);
`ifdef MCPU_FETCH_HALT_EN
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (instr_valid) seen++;
      end
      check("halt_quiet", 32'(seen), 0);
      check("halt_pc_frozen", 32'(irom_addr0), 32'h12);
      redirect(16'h20);
      @(negedge clk);
      check("halt_resume_valid", 32'(instr_valid), 1);
      check("halt_resume_pc", 32'(instr_pc), 32'h20);
      check("halt_resume_op", 32'(instr_op), 32'h0A);
`else
      seen = 0;
      @(negedge clk);
      check("ff_next_pc", 32'(instr_pc), 32'h12);
      check("ff_next_op", 32'(instr_op), 32'h01);
      check("ff_next_len", 32'(instr_len), 1);
      check("ff_next_arg", 32'(instr_arg), 32'(seen));
`endif

      // Reset asserted between clock edges clears the outputs immediately.
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_zero("midrst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rf_valid", 32'(instr_valid), 1);
      check("rf_pc", 32'(instr_pc), 0);
      check("rf_op", 32'(instr_op), 32'h5A);
      check("rf_len", 32'(instr_len), 1);
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
